// File: rtl/mul_appr_ctrl.sv
// Control front-end for an approximate multiplier: latches width/approximation
// configuration, sign-extends operands and registers the product in a 2-stage pipeline.
module mul_appr_ctrl #(
    parameter int DATA_W = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    input  logic [3:0]            cfg_wa_i,
    input  logic [3:0]            cfg_wb_i,
    input  logic [7:0]            cfg_appr_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_a_i,
    input  logic [DATA_W-1:0]     in_b_i,
    output logic [DATA_W-1:0]     mul_a_o,
    output logic [DATA_W-1:0]     mul_b_o,
    output logic [2*DATA_W-5:0]   mul_res_mask_o,
    output logic [7:0]            mul_appr_mask_o,
    input  logic [2*DATA_W-1:0]   mul_res_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [2*DATA_W-1:0]   out_res_o,
    output logic [15:0]           out_cnt_o
);

    localparam int RES_W  = 2 * DATA_W;
    localparam int MASK_W = RES_W - 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    function automatic logic [3:0] clamp_w(input logic [3:0] w);
        if (w < 4'd2)
            return 4'd2;
        else if (w > 4'(DATA_W))
            return 4'(DATA_W);
        else
            return w;
    endfunction

    // Replicate bit w-1 above the effective width; w is always clamped to 2..DATA_W.
    function automatic logic signed [DATA_W-1:0] sext(input logic [DATA_W-1:0] v,
                                                      input logic [3:0] w);
        logic signed [DATA_W-1:0] r;
        logic                     s;
        s = v[w - 4'd1];
        for (int i = 0; i < DATA_W; i++)
            r[i] = (i < int'(w)) ? v[i] : s;
        return r;
    endfunction

    function automatic logic [MASK_W-1:0] res_mask(input logic [3:0] wa, input logic [3:0] wb);
        logic [MASK_W-1:0] m;
        logic [4:0]        ew;
        ew = {1'b0, wa} + {1'b0, wb};
        for (int i = 0; i < MASK_W; i++)
            m[i] = (5'(i) + 5'd5) <= ew;
        return m;
    endfunction

    logic [1:0]               state;
    logic [3:0]               wa_q;
    logic [3:0]               wb_q;
    logic [MASK_W-1:0]        res_mask_q;
    logic [7:0]               appr_q;
    logic [15:0]              cnt_q;
    logic                     vld_p1;
    logic                     vld_p2;
    logic signed [DATA_W-1:0] a_p1;
    logic signed [DATA_W-1:0] b_p1;
    logic signed [RES_W-1:0]  res_p2;

    logic adv_p1, adv_p2;
    logic cfg_hs, in_hs, out_hs;
    logic [3:0] wa_new, wb_new;

    always_comb begin
        adv_p2      = !vld_p2 || out_ready_i;
        adv_p1      = !vld_p1 || adv_p2;
        cfg_ready_o = (state == IDLE) || ((state == DRAIN) && !vld_p1 && !vld_p2);
        in_ready_o  = (state == RUN) && adv_p1;
        cfg_hs      = cfg_valid_i && cfg_ready_o;
        in_hs       = in_valid_i && in_ready_o;
        out_hs      = vld_p2 && out_ready_i;
        wa_new      = clamp_w(cfg_wa_i);
        wb_new      = clamp_w(cfg_wb_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            wa_q       <= 4'(DATA_W);
            wb_q       <= 4'(DATA_W);
            res_mask_q <= '1;
            appr_q     <= '1;
            cnt_q      <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            res_p2     <= '0;
        end else begin
            case (state)
                IDLE:    if (cfg_hs) state <= RUN;
                RUN:     if (cfg_valid_i) state <= DRAIN;
                DRAIN:   if (cfg_hs) state <= RUN;
                default: state <= IDLE;
            endcase

            if (cfg_hs) begin
                wa_q       <= wa_new;
                wb_q       <= wb_new;
                res_mask_q <= res_mask(wa_new, wb_new);
                appr_q     <= cfg_appr_i;
            end

            if (cfg_hs)
                cnt_q <= '0;
            else if (out_hs)
                cnt_q <= cnt_q + 16'd1;

            // Stage p1: sign-extended operands presented to the multiplier
            if (adv_p1) begin
                vld_p1 <= in_hs;
                if (in_hs) begin
                    a_p1 <= sext(in_a_i, wa_q);
                    b_p1 <= sext(in_b_i, wb_q);
                end
            end

            // Stage p2: registered product
            if (adv_p2) begin
                vld_p2 <= vld_p1;
                if (vld_p1)
                    res_p2 <= mul_res_i;
            end
        end
    end

    assign mul_a_o         = a_p1;
    assign mul_b_o         = b_p1;
    assign mul_res_mask_o  = res_mask_q;
    assign mul_appr_mask_o = appr_q;
    assign out_valid_o     = vld_p2;
    assign out_res_o       = res_p2;
    assign out_cnt_o       = cnt_q;

endmodule

// File: tb/tb_mul_appr_ctrl.sv
// Bench for mul_appr_ctrl: acts as an exact multiplier and checks directed and
// random traffic against an arithmetic reference model with a result queue.
module tb_mul_appr_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_wa;
    logic [3:0]  cfg_wb;
    logic [7:0]  cfg_appr;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_a;
    logic [8:0]  in_b;
    logic [8:0]  mul_a;
    logic [8:0]  mul_b;
    logic [13:0] res_mask;
    logic [7:0]  appr_mask;
    logic [17:0] mul_res;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_res;
    logic [15:0] out_cnt;

    int checks = 0;
    int errors = 0;

    logic [17:0] q[$];
    int          cnt_m;
    int          wa_m, wb_m, appr_m;
    logic        last_in_hs;

    mul_appr_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_wa_i        (cfg_wa),
        .cfg_wb_i        (cfg_wb),
        .cfg_appr_i      (cfg_appr),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_a_i          (in_a),
        .in_b_i          (in_b),
        .mul_a_o         (mul_a),
        .mul_b_o         (mul_b),
        .mul_res_mask_o  (res_mask),
        .mul_appr_mask_o (appr_mask),
        .mul_res_i       (mul_res),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_res_o       (out_res),
        .out_cnt_o       (out_cnt)
    );

    // Exact signed multiplier standing in for the approximate one.
    logic signed [17:0] ea, eb;
    assign ea      = {{9{mul_a[8]}}, mul_a};
    assign eb      = {{9{mul_b[8]}}, mul_b};
    assign mul_res = ea * eb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int clamp_m(input int w);
        return (w < 2) ? 2 : ((w > 9) ? 9 : w);
    endfunction

    function automatic int mask_m(input int wa, input int wb);
        int ew;
        ew = wa + wb;
        return (ew >= 5) ? ((1 << (ew - 4)) - 1) : 0;
    endfunction

    function automatic logic [17:0] prod_m(input logic [8:0] a, input logic [8:0] b,
                                           input int wa, input int wb);
        int va, vb, p;
        va = int'(a) & ((1 << wa) - 1);
        if (va >= (1 << (wa - 1))) va -= (1 << wa);
        vb = int'(b) & ((1 << wb) - 1);
        if (vb >= (1 << (wb - 1))) vb -= (1 << wb);
        p = va * vb;
        return p[17:0];
    endfunction

    function automatic logic [8:0] sext_m(input logic [8:0] a, input int w);
        int v;
        v = int'(a) & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v -= (1 << w);
        return v[8:0];
    endfunction

    // One clock: record handshakes seen before the edge, update the model, check after it.
    task automatic cycle();
        logic ih, oh, ch;
        #1;
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        ch = cfg_valid && cfg_ready;
        if (oh) begin
            if (q.size() == 0) chk("spurious_out", 32'(1), 32'(0));
            else chk("out_res", 32'(out_res), 32'(q.pop_front()));
        end
        if (ih) q.push_back(prod_m(in_a, in_b, wa_m, wb_m));
        if (ch) begin
            wa_m   = clamp_m(int'(cfg_wa));
            wb_m   = clamp_m(int'(cfg_wb));
            appr_m = int'(cfg_appr);
            cnt_m  = 0;
        end else if (oh) begin
            cnt_m = (cnt_m + 1) & 16'hFFFF;
        end
        last_in_hs = ih;
        @(posedge clk);
        #1;
        chk("out_cnt", 32'(out_cnt), 32'(cnt_m));
        if (ch) begin
            chk("res_mask", 32'(res_mask), 32'(mask_m(wa_m, wb_m)));
            chk("appr_mask", 32'(appr_mask), 32'(appr_m));
            cfg_valid = 1'b0;
        end
    endtask

    task automatic configure(input logic [3:0] wa, input logic [3:0] wb, input logic [7:0] ap);
        in_valid  = 1'b0;
        cfg_wa    = wa;
        cfg_wb    = wb;
        cfg_appr  = ap;
        cfg_valid = 1'b1;
        for (int i = 0; i < 20 && cfg_valid; i++) cycle();
        if (cfg_valid) begin
            chk("cfg_timeout", 32'(0), 32'(1));
            cfg_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({pfx, "_in_ready"}, 32'(in_ready), 32'(0));
        chk({pfx, "_cfg_ready"}, 32'(cfg_ready), 32'(1));
        chk({pfx, "_res_mask"}, 32'(res_mask), 32'h3FFF);
        chk({pfx, "_appr_mask"}, 32'(appr_mask), 32'hFF);
        chk({pfx, "_out_cnt"}, 32'(out_cnt), 32'(0));
        chk({pfx, "_out_res"}, 32'(out_res), 32'(0));
        chk({pfx, "_mul_a"}, 32'(mul_a), 32'(0));
        chk({pfx, "_mul_b"}, 32'(mul_b), 32'(0));
    endtask

    task automatic model_reset();
        q.delete();
        cnt_m  = 0;
        wa_m   = 9;
        wb_m   = 9;
        appr_m = 8'hFF;
    endtask

    initial begin
        logic [8:0]  opa [4];
        logic [8:0]  opb [4];
        logic [17:0] hold;
        int          idx;

        rst = 1'b1; cfg_valid = 1'b0; cfg_wa = '0; cfg_wb = '0; cfg_appr = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1; last_in_hs = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("rst");

        // Full width, product -1 * 2
        configure(4'd9, 4'd9, 8'hFF);
        chk("run_cfg_ready", 32'(cfg_ready), 32'(0));
        chk("run_in_ready", 32'(in_ready), 32'(1));
        in_a = 9'h1FF; in_b = 9'h002; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("full_mul_a", 32'(mul_a), 32'h1FF);
        chk("full_mul_b", 32'(mul_b), 32'h002);
        chk("lat1_out_valid", 32'(out_valid), 32'(0));
        cycle();
        chk("lat2_out_valid", 32'(out_valid), 32'(1));
        chk("full_out_res", 32'(out_res), 32'h3FFFE);
        cycle();
        chk("full_cnt", 32'(out_cnt), 32'(1));

        // Reduced A width
        configure(4'd5, 4'd9, 8'h0F);
        chk("w5_res_mask", 32'(res_mask), 32'h03FF);
        in_a = 9'h1F0; in_b = 9'h003; in_valid = 1'b1;
        cycle();
        chk("w5_mul_a0", 32'(mul_a), 32'(sext_m(9'h1F0, 5)));
        in_a = 9'h010;
        cycle();
        chk("w5_mul_a1", 32'(mul_a), 32'h1F0);
        in_a = 9'h1EF;
        cycle();
        chk("w5_mul_a2", 32'(mul_a), 32'h00F);
        in_valid = 1'b0;
        repeat (3) cycle();

        // Width clamping
        configure(4'd1, 4'd15, 8'h55);
        chk("clamp_res_mask", 32'(res_mask), 32'h007F);
        in_a = 9'h0FF; in_b = 9'h1FF; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("clamp_mul_a", 32'(mul_a), 32'h1FF);
        cycle();
        chk("clamp_out_res", 32'(out_res), 32'h00001);
        cycle();

        // Backpressure: 4 operands, out_ready low for 5 cycles
        configure(4'd9, 4'd9, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            opa[i] = 9'($urandom);
            opb[i] = 9'($urandom);
        end
        out_ready = 1'b0;
        idx  = 0;
        hold = '0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_a = opa[idx]; in_b = opb[idx]; end
            cycle();
            if (last_in_hs) idx++;
            if (c == 2) hold = out_res;
        end
        chk("bp_accepts", 32'(idx), 32'(2));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        chk("bp_out_valid", 32'(out_valid), 32'(1));
        chk("bp_hold", 32'(out_res), 32'(hold));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 4 || q.size() > 0); c++) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_a = opa[idx]; in_b = opb[idx]; end
            cycle();
            if (last_in_hs) idx++;
        end
        in_valid = 1'b0;
        chk("bp_cnt", 32'(out_cnt), 32'(4));
        chk("bp_queue_empty", 32'(q.size()), 32'(0));

        // Reconfiguration with two results in flight
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            in_valid = 1'b1; in_a = 9'($urandom); in_b = 9'($urandom);
            cycle();
            if (last_in_hs) idx++;
        end
        chk("rc_filled", 32'(idx), 32'(2));
        cfg_wa = 4'd4; cfg_wb = 4'd4; cfg_appr = 8'h33; cfg_valid = 1'b1;
        cycle();
        chk("rc_in_ready_drain", 32'(in_ready), 32'(0));
        chk("rc_cfg_ready_full", 32'(cfg_ready), 32'(0));
        out_ready = 1'b1;
        cycle();
        chk("rc_cfg_ready_one", 32'(cfg_ready), 32'(0));
        chk("rc_mask_held", 32'(res_mask), 32'h3FFF);
        cycle();
        chk("rc_cfg_ready_empty", 32'(cfg_ready), 32'(1));
        chk("rc_in_ready_empty", 32'(in_ready), 32'(0));
        in_valid = 1'b0;
        cycle();
        chk("rc_res_mask", 32'(res_mask), 32'h000F);
        chk("rc_appr", 32'(appr_mask), 32'h33);
        chk("rc_cnt", 32'(out_cnt), 32'(0));
        chk("rc_in_ready_run", 32'(in_ready), 32'(1));

        // Random traffic with occasional reconfiguration
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 9'($urandom);
            in_b      = 9'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!cfg_valid && $urandom_range(0, 39) == 0) begin
                cfg_wa    = 4'($urandom);
                cfg_wb    = 4'($urandom);
                cfg_appr  = 8'($urandom);
                cfg_valid = 1'b1;
            end
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (q.size() > 0 || cfg_valid); c++) cycle();
        chk("rand_drain_empty", 32'(q.size()), 32'(0));
        chk("rand_cfg_done", 32'(cfg_valid), 32'(0));

        // Reset with both stages full
        configure(4'd9, 4'd9, 8'h81);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6 && idx < 2; c++) begin
            in_valid = 1'b1; in_a = 9'($urandom); in_b = 9'($urandom);
            cycle();
            if (last_in_hs) idx++;
        end
        chk("mr_filled", 32'(idx), 32'(2));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_reset();
        chk_reset_state("mr");
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("mr_no_output", 32'(out_valid), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
